riscv_pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, successor to the fixed-field ID/EX register. It carries one control vector and one payload vector between adjacent pipeline stages under a valid/ready handshake, with an optional 2-entry skid buffer. It provides flush-to-bubble and freeze (stall), and a saturating back-pressure counter. It is instantiated at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB); the hazard unit drives `flush` and `stall`.

---
 rtl/riscv_pipe_stage_reg.sv | 100 ++++++++++
 tb/tb_riscv_pipe_stage_reg.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, optional 2-entry skid,
// flush-to-bubble, stall freeze and a saturating back-pressure counter.
module riscv_pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              stall,
  output logic [CNT_W-1:0]  bp_cnt,
  input  logic              bp_clr
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t h_q, s_q, in_e;
  logic   h_valid, s_valid;
  logic   accept, emit;

  assign in_e = '{ctrl: in_ctrl, data: in_data};

  // Skid mode keeps out_ready off the in_ready path; the spare slot absorbs the in-flight entry.
  generate
    if (SKID != 0) begin : g_skid_rdy
      assign in_ready = !s_valid && !stall;
    end else begin : g_pass_rdy
      assign in_ready = (!h_valid || out_ready) && !stall;
    end
  endgenerate

  assign out_valid = h_valid && !stall;
  assign out_ctrl  = out_valid ? h_q.ctrl : '0;
  assign out_data  = h_q.data;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
      h_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
      h_q     <= '0;
      s_q     <= '0;
    end else if (!stall) begin
      if (!h_valid) begin
        if (accept) begin
          h_valid <= 1'b1;
          h_q     <= in_e;
        end
      end else if (!s_valid) begin
        if (accept && emit) begin
          h_q <= in_e;
        end else if (accept && SKID != 0) begin
          s_valid <= 1'b1;
          s_q     <= in_e;
        end else if (emit) begin
          h_valid <= 1'b0;
          h_q     <= '0;
        end
      end else if (emit) begin
        // FULL: skid advances to head; in_ready is low so nothing new arrives this cycle.
        h_q     <= s_q;
        s_valid <= 1'b0;
        s_q     <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_cnt <= '0;
    end else if (bp_clr) begin
      bp_cnt <= '0;
    end else if (out_valid && !out_ready && bp_cnt != CNT_MAX) begin
      bp_cnt <= bp_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_pipe_stage_reg.sv
// Scoreboard bench: drivers push expected entries, per-DUT monitors pop on each emit.
module tb_riscv_pipe_stage_reg;

  typedef struct {
    logic [15:0]  c;
    logic [159:0] d;
    int           cyc;
  } exp_t;

  logic clk, rst_n;
  int   checks, failures, cyc;

  // DUT0: SKID=1, CNT_W=16; DUT2 shares its inputs with CNT_W=4
  logic         iv, ir, ov, ordy, fl, st, bclr;
  logic [15:0]  ic, oc, bp;
  logic [159:0] id, od;
  logic         ir2, ov2;
  logic [15:0]  oc2;
  logic [159:0] od2;
  logic [3:0]   bp2;
  // DUT1: SKID=0
  logic         iv1, ir1, ov1, or1;
  logic [15:0]  ic1, oc1, bp1;
  logic [159:0] id1, od1;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int   n1, seq;

  riscv_pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .SKID(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_ctrl(ic), .in_data(id),
    .out_valid(ov), .out_ready(ordy), .out_ctrl(oc), .out_data(od),
    .flush(fl), .stall(st), .bp_cnt(bp), .bp_clr(bclr));

  riscv_pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .SKID(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir2), .in_ctrl(ic), .in_data(id),
    .out_valid(ov2), .out_ready(ordy), .out_ctrl(oc2), .out_data(od2),
    .flush(fl), .stall(st), .bp_cnt(bp2), .bp_clr(bclr));

  riscv_pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .SKID(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_ctrl(oc1), .out_data(od1),
    .flush(1'b0), .stall(1'b0), .bp_cnt(bp1), .bp_clr(1'b0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [159:0] d, input logic [15:0] c, input bit keep, input bit lat);
    bit ok;
    int n;
    n  = 0;
    ok = 1'b0;
    iv = 1'b1; id = d; ic = c;
    do begin
      @(negedge clk);
      ok = ir;
      @(posedge clk);
      n++;
    end while (!ok && n < 100);
    #1 iv = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL push_timeout: data %0h not accepted within 100 cycles", d);
    end else if (keep) begin
      q0.push_back('{c: c, d: d, cyc: lat ? cyc : -1});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov && ordy) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL emit0_unexpected: got data %0h, expected no entry", od);
        end else begin
          e0 = q0.pop_front();
          chk("emit0_data", od, e0.d);
          chk("emit0_ctrl", oc, e0.c);
          if (e0.cyc >= 0) chk("emit0_latency", cyc, e0.cyc);
        end
      end else if (!ov) begin
        chk("idle0_ctrl", oc, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      n1++;
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL emit1_unexpected: got data %0h, expected no entry", od1);
      end else begin
        e1 = q1.pop_front();
        chk("emit1_data", od1, e1.d);
        chk("emit1_ctrl", oc1, e1.c);
      end
    end
  end

  initial begin
    logic acc;
    checks = 0; failures = 0; n1 = 0; seq = 0;
    iv = 0; ordy = 0; fl = 0; st = 0; bclr = 0; ic = '0; id = '0;
    iv1 = 0; or1 = 0; ic1 = '0; id1 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", ir, 1);
    chk("rst_out_valid", ov, 0);
    chk("rst_bp_cnt", bp, 0);

    // streaming, latency 1
    tick();
    ordy = 1;
    for (int i = 0; i < 8; i++) push(160'(i), 16'h8000 | 16'(i), 1, 1);
    repeat (3) tick();

    // back-pressure mid-stream for 3 cycles
    fork
      begin
        for (int i = 16; i < 24; i++) push(160'(i), 16'h8000 | 16'(i), 1, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 ordy = 0;
        tick();
        @(negedge clk); chk("bp_in_ready_c2", ir, 0);
        tick();
        @(negedge clk); chk("bp_in_ready_c3", ir, 0);
        tick();
        ordy = 1;
        @(negedge clk); chk("bp_cnt_3", bp, 3);
      end
    join
    repeat (4) tick();
    chk("bp_drained", q0.size(), 0);

    // flush from FULL with a pending input
    ordy = 0;
    push(160'hA, 16'h800A, 0, 0);
    push(160'hB, 16'h800B, 0, 0);
    iv = 1; id = 160'hC; ic = 16'h800C; fl = 1;
    tick();
    fl = 0; iv = 0;
    @(negedge clk);
    chk("flush_out_valid", ov, 0);
    chk("flush_in_ready", ir, 1);
    chk("flush_out_data", od, 0);
    tick();
    ordy = 1;
    repeat (3) tick();

    // stall with head=5
    ordy = 0;
    push(160'h5, 16'h8005, 1, 0);
    st = 1; ordy = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_out_valid", ov, 0);
      chk("stall_out_ctrl", oc, 0);
      chk("stall_in_ready", ir, 0);
      chk("stall_out_data", od, 160'h5);
      tick();
    end
    st = 0;
    repeat (3) tick();
    chk("stall_drained", q0.size(), 0);

    // stall and flush together
    ordy = 0;
    push(160'h6, 16'h8006, 0, 0);
    st = 1; fl = 1;
    tick();
    st = 0; fl = 0;
    @(negedge clk);
    chk("stflush_out_valid", ov, 0);
    chk("stflush_out_data", od, 0);
    chk("stflush_in_ready", ir, 1);
    tick();
    ordy = 1;
    repeat (3) tick();

    // saturating counter and clear
    bclr = 1;
    tick();
    bclr = 0;
    ordy = 0;
    push(160'h9, 16'h8009, 0, 0);
    repeat (20) tick();
    @(negedge clk);
    chk("bp_cnt_20", bp, 20);
    chk("bp_cnt_sat4", bp2, 15);
    tick();
    bclr = 1;
    tick();
    bclr = 0;
    @(negedge clk);
    chk("bp_clr_16", bp, 0);
    chk("bp_clr_4", bp2, 0);
    tick();
    @(negedge clk);
    chk("bp_after_clr", bp2, 1);
    tick();
    fl = 1;
    tick();
    fl = 0;

    // reset mid-transfer from FULL
    push(160'h7, 16'h8007, 0, 0);
    push(160'h8, 16'h8008, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", ov, 0);
    chk("arst_out_ctrl", oc, 0);
    chk("arst_out_data", od, 0);
    chk("arst_bp_cnt", bp, 0);
    chk("arst_bp_cnt4", bp2, 0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", ir, 1);
    ordy = 1;

    // SKID=0: combinational out_ready -> in_ready
    tick();
    or1 = 0; iv1 = 1; id1 = 160'(seq); ic1 = 16'h4000 | 16'(seq);
    @(negedge clk);
    chk("s0_ready_empty", ir1, 1);
    q1.push_back('{c: ic1, d: id1, cyc: -1});
    tick();
    iv1 = 0; seq++;
    @(negedge clk);
    chk("s0_ready_full", ir1, 0);
    chk("s0_out_valid", ov1, 1);
    tick();
    or1 = 1;
    #1 chk("s0_ready_comb", ir1, 1);

    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      acc = iv1 && ir1;
      if (acc) q1.push_back('{c: ic1, d: id1, cyc: -1});
      @(posedge clk);
      #1;
      if (acc) seq++;
      if (acc || !iv1) begin
        iv1 = ($urandom_range(0, 2) != 0);
        id1 = 160'(seq) ^ {32'hC0DE_0000, 128'h0};
        ic1 = 16'h4000 | 16'(seq & 16'hfff);
      end
      or1 = ($urandom_range(0, 3) != 0);
    end
    iv1 = 0; or1 = 1;
    repeat (5) tick();
    chk("s0_drained", q1.size(), 0);
    chk("s0_emit_count", n1, seq);
    chk("s1_drained_end", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
